mem_req_scheduler: RTL
======================

Name: mem_req_scheduler

Overview:
- Shares one single-port scratchpad/SRAM between NUM_REQ requesters (DMA, PE array loaders, writeback, host).
- Uses round-robin arbitration with optional burst lock and a fixed read-latency response pipeline.
- Routes each read response back to the requester that issued it.
- Sits between the NPU engines and the memory macro, above the bank-level memory interface.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, requester index width; must equal clog2(NUM_REQ).
- MEM_LAT, 2, fixed cycles from mem_ce (read) to valid mem_rdata (1..4).
- ADDR_WIDTH, from npu_definitions.vh, address width.
- DATA_WIDTH, from npu_definitions.vh, data width.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; a beat transfers when valid&ready.
- req_we  in  NUM_REQ  1 = write, 0 = read.
- req_lock  in  NUM_REQ  keep the grant after this beat (burst).
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i is at slice i.
- req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data.
- resp_valid  out  NUM_REQ  one-hot read-data valid.
- resp_rdata  out  DATA_WIDTH  read data shared by all requesters, qualified by resp_valid.
- mem_ready  in  1  memory can accept a command this cycle.
- mem_ce  out  1  memory command strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_rdata  in  DATA_WIDTH  read data, valid MEM_LAT cycles after a read mem_ce.
- busy  out  1  a lock is held or a read is in flight.

Behaviour:
- Reset values: req_ready=0, resp_valid=0, mem_ce=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0. The round-robin pointer resets to 0, the state resets to ARB, and the in-flight pipeline is cleared.
- Arbitration is combinational within the cycle. Winner = first requester with req_valid, searching from rr_ptr upward with wrap-around.
- req_ready[w]=1 only for the winner, and only when mem_ready=1. All other req_ready bits are 0.
- Command issue is registered. On handshake, the next cycle drives mem_ce=1 with mem_we/mem_addr/mem_wdata captured from the winner. If no handshake occurs, mem_ce=0 the next cycle; addr/wdata hold.
- Throughput is one beat per cycle back-to-back.
- rr_ptr update: on a handshake without req_lock, rr_ptr = winner+1 mod NUM_REQ. A locked beat does not move rr_ptr.
- State machine:
  - ARB: normal arbitration. A handshake with req_lock[w]=1 moves to LOCK and stores lock_id=w.
  - LOCK: only lock_id may be granted, and all other requesters are held off.
  - LOCK -> ARB on a handshake with req_lock=0, or when req_valid[lock_id] drops.
  - The lock carries over cycles where mem_ready=0.
- Response routing:
  - Each issued command pushes {is_read, id} into a MEM_LAT-deep shift pipeline aligned to mem_rdata.
  - When a read reaches the tail, resp_valid[id]=1 for one cycle and resp_rdata=mem_rdata (combinational pass-through of the aligned data).
  - Writes produce no response.
- Response ordering: responses are in issue order, one per cycle maximum. A requester must always accept its response; there is no response backpressure.
- mem_ready=0: no grant; the in-flight pipeline still advances.
- NUM_REQ=1 degenerates to a registered pass-through.
- Reset mid-operation clears the lock and in-flight reads; no response is emitted for dropped reads.
- Index arithmetic wraps mod NUM_REQ; non-power-of-two NUM_REQ is supported.

Optional Feature:
- Macro: MEM_SCHED_AGING_EN.
- Defined:
  - Each requester has a 4-bit wait counter. It increments on cycles where the requester is valid but not granted, saturates at 15, and clears on grant.
  - A requester at 15 wins over round-robin and over a held LOCK. The lowest index wins among several aged requesters.
  - A lock broken by aging returns the state to ARB.
- Undefined: pure round-robin plus lock; no counters are synthesised.

Decomposition:
- npu_definitions.vh: ADDR_WIDTH, DATA_WIDTH, and the state encodings SCHED_ARB=1'b0, SCHED_LOCK=1'b1.
- Sub-module rr_arbiter: combinational rotating priority encoder.
  - Inputs: req vector, pointer.
  - Outputs: one-hot grant, grant index, any.
  - Reused by future DMA channel schedulers.

Test Plan:
- Reset: assert rst 3 cycles with all req_valid=1 -> req_ready=0, mem_ce=0, resp_valid=0 throughout. First grant after release goes to requester 0.
- Fairness: all 4 requesters issue reads continuously with mem_ready=1 -> grant order 0,1,2,3,0,... and mem_ce=1 every cycle. With MEM_LAT=2, requester 0's data (mem_rdata=0xA5) appears at resp_valid=4'b0001 two cycles after its mem_ce.
- Burst lock: requester 2 sends 4 writes with req_lock=1,1,1,0 while requesters 0 and 3 are valid -> 4 consecutive grants to 2, then the next grant goes to 3.
- Backpressure: mem_ready=0 for 5 cycles with requester 1 valid -> req_ready=0 and no mem_ce. In-flight reads still return on schedule. Grant occurs on the cycle mem_ready returns to 1.
- Mid-read reset: issue a read to addr 0x10, assert rst at the cycle after mem_ce -> no resp_valid afterwards, and state is ARB.
- Aging (MEM_SCHED_AGING_EN): requester 0 holds a lock indefinitely while requester 1 is valid -> requester 1 is granted after exactly 15 waiting cycles, and the lock is released.

Source files
------------

// File: rtl/mem_req_scheduler_pkg.sv
// mem_req_scheduler_pkg
//   Shared widths, FSM state encoding and index helper for the memory request
//   scheduler and its round-robin arbiter.
package mem_req_scheduler_pkg;

  localparam int ADDR_WIDTH = 16;
  localparam int DATA_WIDTH = 32;

  // wait-counter width and saturation value used when aging is built in
  localparam int              AGE_W   = 4;
  localparam logic [AGE_W-1:0] AGE_MAX = 4'd15;

  typedef enum logic {
    SCHED_ARB  = 1'b0,
    SCHED_LOCK = 1'b1
  } sched_state_e;

  // idx is always < 2*n here, so one conditional subtract wraps it
  function automatic int wrap_idx(int idx, int n);
    return (idx >= n) ? idx - n : idx;
  endfunction

endpackage

// File: rtl/mem_req_scheduler_rr_arbiter.sv
// rr_arbiter
//   Combinational rotating-priority encoder. The first set bit of req_i found
//   searching upward from ptr_i (with wrap-around) wins.
// Ports:
//   req_i      request vector
//   ptr_i      index holding highest priority this cycle
//   gnt_o      one-hot grant
//   gnt_idx_o  binary index of the granted bit
//   any_o      at least one request present
module rr_arbiter
  import mem_req_scheduler_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] gnt_idx_o,
  output logic             any_o
);

  always_comb begin
    int idx;
    gnt_o     = '0;
    gnt_idx_o = '0;
    any_o     = 1'b0;
    for (int i = 0; i < N; i++) begin
      idx = wrap_idx(int'(ptr_i) + i, N);
      if (!any_o && req_i[idx]) begin
        any_o      = 1'b1;
        gnt_o[idx] = 1'b1;
        gnt_idx_o  = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/mem_req_scheduler.sv
// mem_req_scheduler
//   Shares one single-port SRAM between NUM_REQ requesters. Round-robin
//   arbitration with burst lock, registered command issue, and a MEM_LAT-deep
//   tag pipeline that routes read data back to the issuing requester.
//   Build option MEM_SCHED_AGING_EN adds per-requester 4-bit wait counters;
//   a requester that has waited 15 cycles pre-empts round-robin and any lock.
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   req_*_i / req_ready_o   per-requester command channel (valid/ready)
//   resp_valid_o        one-hot read-data valid, resp_rdata_o shared data
//   mem_ready_i         memory accepts a command this cycle
//   mem_ce_o/we/addr/wdata  registered memory command
//   mem_rdata_i         read data, MEM_LAT cycles after a read mem_ce_o
//   busy_o              lock held or a read in flight
//
// state      | meaning
// SCHED_ARB  | round-robin among all valid requesters
// SCHED_LOCK | only lock_id may be granted (burst in progress)
module mem_req_scheduler
  import mem_req_scheduler_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int MEM_LAT = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic [NUM_REQ-1:0]            req_we_i,
  input  logic [NUM_REQ-1:0]            req_lock_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata_i,
  output logic [NUM_REQ-1:0]            resp_valid_o,
  output logic [DATA_WIDTH-1:0]         resp_rdata_o,
  input  logic                          mem_ready_i,
  output logic                          mem_ce_o,
  output logic                          mem_we_o,
  output logic [ADDR_WIDTH-1:0]         mem_addr_o,
  output logic [DATA_WIDTH-1:0]         mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]         mem_rdata_i,
  output logic                          busy_o
);

  typedef struct packed {
    logic            rd;
    logic [ID_W-1:0] id;
  } pipe_ent_t;

  sched_state_e     state_q, state_d;
  logic [ID_W-1:0]  lock_id_q, lock_id_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;

  logic [NUM_REQ-1:0] arb_req, arb_gnt;
  logic [ID_W-1:0]    arb_idx, win_idx;
  logic               arb_any, win_any, hs;

  logic               age_win;
  logic [ID_W-1:0]    aged_idx;
  logic [NUM_REQ-1:0] aged_gnt;

  logic                  mem_ce_q, mem_we_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;
  logic [ID_W-1:0]       id_q;
  pipe_ent_t             pipe_q [MEM_LAT];

  // while locked, everyone except the lock holder is masked off
  always_comb begin
    arb_req = req_valid_i;
    if (state_q == SCHED_LOCK) begin
      arb_req             = '0;
      arb_req[lock_id_q]  = req_valid_i[lock_id_q];
    end
  end

  rr_arbiter #(.N(NUM_REQ), .IDX_W(ID_W)) u_rr_arbiter (
    .req_i     (arb_req),
    .ptr_i     (rr_ptr_q),
    .gnt_o     (arb_gnt),
    .gnt_idx_o (arb_idx),
    .any_o     (arb_any)
  );

`ifdef MEM_SCHED_AGING_EN
  logic [AGE_W-1:0] age_q [NUM_REQ];

  // descending scan so the lowest aged index is the one left standing
  always_comb begin
    age_win  = 1'b0;
    aged_idx = '0;
    aged_gnt = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid_i[i] && (age_q[i] == AGE_MAX)) begin
        age_win  = 1'b1;
        aged_idx = ID_W'(i);
        aged_gnt = NUM_REQ'(1) << i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rst_i || req_ready_o[i] || !req_valid_i[i]) begin
        age_q[i] <= '0;
      end else if (age_q[i] != AGE_MAX) begin
        age_q[i] <= age_q[i] + 1'b1;
      end
    end
  end
`else
  assign age_win  = 1'b0;
  assign aged_idx = '0;
  assign aged_gnt = '0;
`endif

  always_comb begin
    win_any     = age_win || arb_any;
    win_idx     = age_win ? aged_idx : arb_idx;
    hs          = win_any && mem_ready_i && !rst_i;
    req_ready_o = '0;
    if (hs) begin
      req_ready_o = age_win ? aged_gnt : arb_gnt;
    end
  end

  // an aged grant always ends in ARB, which is how it breaks a held lock
  always_comb begin
    state_d   = state_q;
    lock_id_d = lock_id_q;
    rr_ptr_d  = rr_ptr_q;
    if (hs) begin
      if (req_lock_i[win_idx] && !age_win) begin
        state_d   = SCHED_LOCK;
        lock_id_d = win_idx;
      end else begin
        state_d  = SCHED_ARB;
        rr_ptr_d = ID_W'(wrap_idx(int'(win_idx) + 1, NUM_REQ));
      end
    end else if ((state_q == SCHED_LOCK) && !req_valid_i[lock_id_q]) begin
      state_d = SCHED_ARB;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= SCHED_ARB;
      lock_id_q   <= '0;
      rr_ptr_q    <= '0;
      mem_ce_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      id_q        <= '0;
    end else begin
      state_q   <= state_d;
      lock_id_q <= lock_id_d;
      rr_ptr_q  <= rr_ptr_d;
      mem_ce_q  <= hs;
      if (hs) begin
        mem_we_q    <= req_we_i[win_idx];
        mem_addr_q  <= req_addr_i[int'(win_idx)*ADDR_WIDTH +: ADDR_WIDTH];
        mem_wdata_q <= req_wdata_i[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
        id_q        <= win_idx;
      end
    end
  end

  // stage 0 is loaded in the cycle after mem_ce, so the tail lines up with
  // mem_rdata exactly MEM_LAT cycles after the command
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < MEM_LAT; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= '{rd: mem_ce_q && !mem_we_q, id: id_q};
      for (int i = 1; i < MEM_LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  always_comb begin
    resp_valid_o = '0;
    if (pipe_q[MEM_LAT-1].rd) begin
      resp_valid_o[pipe_q[MEM_LAT-1].id] = 1'b1;
    end
  end

  always_comb begin
    busy_o = (state_q == SCHED_LOCK) || (mem_ce_q && !mem_we_q);
    for (int i = 0; i < MEM_LAT; i++) busy_o = busy_o || pipe_q[i].rd;
  end

  assign resp_rdata_o = mem_rdata_i;
  assign mem_ce_o     = mem_ce_q;
  assign mem_we_o     = mem_we_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wdata_o  = mem_wdata_q;

endmodule
